// File: rtl/cv32e41p_register_file_mp_if.sv
// Bus interface of the multi-port register file: read, write and scoreboard signals.
// The register file's write-bypass option is selected by CV32E41P_RF_WRITE_BYPASS_EN.
interface cv32e41p_register_file_mp_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RPORTS = 3,
  parameter int unsigned NUM_WPORTS = 2
);
  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i;
  logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o;
  logic [NUM_RPORTS-1:0]            rbusy_o;
  logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr_i;
  logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_WPORTS-1:0]            we_i;
  logic                             sb_set_i;
  logic [ADDR_WIDTH-1:0]            sb_addr_i;
  logic                             any_busy_o;

  modport master (
    output raddr_i, waddr_i, wdata_i, we_i, sb_set_i, sb_addr_i,
    input  rdata_o, rbusy_o, any_busy_o
  );

  modport slave (
    input  raddr_i, waddr_i, wdata_i, we_i, sb_set_i, sb_addr_i,
    output rdata_o, rbusy_o, any_busy_o
  );
endinterface

// File: rtl/cv32e41p_register_file_mp.sv
// Flop-based multi-port register file with a per-register pending-write scoreboard.
// Define CV32E41P_RF_WRITE_BYPASS_EN to forward same-cycle write data onto the read ports.
module cv32e41p_register_file_mp #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RPORTS = 3,
  parameter int unsigned NUM_WPORTS = 2,
  parameter int unsigned ZERO_REG   = 1
) (
  input logic                        clk,
  input logic                        rst,
  cv32e41p_register_file_mp_if.slave bus
);
  localparam int unsigned NUM_WORDS = 32'(1) << ADDR_WIDTH;
  localparam bit          HARD_ZERO = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0]            r_mem [NUM_WORDS];
  logic [NUM_WORDS-1:0]             r_busy;

  logic [ADDR_WIDTH-1:0]            w_waddr [NUM_WPORTS];
  logic [DATA_WIDTH-1:0]            w_wdata [NUM_WPORTS];
  logic [NUM_WPORTS-1:0]            w_wvalid;
  logic [ADDR_WIDTH-1:0]            w_raddr [NUM_RPORTS];
  logic                             w_sb_valid;
  logic [NUM_RPORTS*DATA_WIDTH-1:0] w_rdata;
  logic [NUM_RPORTS-1:0]            w_rbusy;

  // Unpack the bus and drop writes/sets aimed at the hard-wired zero register
  always_comb begin
    w_wvalid = '0;
    for (int unsigned w = 0; w < NUM_WPORTS; w++) begin
      w_waddr[w]  = bus.waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH];
      w_wdata[w]  = bus.wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
      w_wvalid[w] = bus.we_i[w] && !(HARD_ZERO && (w_waddr[w] == '0));
    end
    for (int unsigned p = 0; p < NUM_RPORTS; p++) begin
      w_raddr[p] = bus.raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
    end
    w_sb_valid = bus.sb_set_i && !(HARD_ZERO && (bus.sb_addr_i == '0));
  end

  // Ascending port order lets the highest-index writer win; the set comes last so it beats a retiring clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WPORTS; w++) begin
        if (w_wvalid[w]) begin
          r_mem[w_waddr[w]]  <= w_wdata[w];
          r_busy[w_waddr[w]] <= 1'b0;
        end
      end
      if (w_sb_valid) begin
        r_busy[bus.sb_addr_i] <= 1'b1;
      end
    end
  end

  // Combinational read path
  always_comb begin
    w_rdata = '0;
    w_rbusy = '0;
    for (int unsigned p = 0; p < NUM_RPORTS; p++) begin
      w_rdata[p*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_raddr[p]];
      w_rbusy[p]                          = r_busy[w_raddr[p]];
`ifdef CV32E41P_RF_WRITE_BYPASS_EN
      for (int unsigned w = 0; w < NUM_WPORTS; w++) begin
        if (w_wvalid[w] && (w_waddr[w] == w_raddr[p])) begin
          w_rdata[p*DATA_WIDTH +: DATA_WIDTH] = w_wdata[w];
          w_rbusy[p] = w_sb_valid && (bus.sb_addr_i == w_raddr[p]);
        end
      end
`endif
      if (HARD_ZERO && (w_raddr[p] == '0)) begin
        w_rdata[p*DATA_WIDTH +: DATA_WIDTH] = '0;
        w_rbusy[p]                          = 1'b0;
      end
    end
  end

  assign bus.rdata_o    = w_rdata;
  assign bus.rbusy_o    = w_rbusy;
  assign bus.any_busy_o = |r_busy;

endmodule

// File: tb/tb_cv32e41p_register_file_mp.sv
// Self-checking bench for cv32e41p_register_file_mp: directed cases plus randomized traffic
// against an array-based reference model (honours CV32E41P_RF_WRITE_BYPASS_EN).
module tb_cv32e41p_register_file_mp;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 3;
  localparam int unsigned NW = 2;
  localparam int unsigned NWORDS = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cv32e41p_register_file_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR), .NUM_WPORTS(NW)) bus ();

  cv32e41p_register_file_mp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR), .NUM_WPORTS(NW), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: one word and one pending flag per architectural register
  logic [DW-1:0] m_mem  [NWORDS];
  logic          m_busy [NWORDS];
  bit            m_valid = 1'b0;
  bit            mdl_hit;
  logic [DW-1:0] mdl_d;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return bus.rdata_o[p*DW +: DW];
  endfunction

  function automatic logic rb(input int p);
    return bus.rbusy_o[p];
  endfunction

  // Register a is written this cycle by some port; returns the data of the highest such port
  function automatic bit write_hit(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bit hit = 1'b0;
    d = '0;
    for (int w = 0; w < NW; w++) begin
      if (bus.we_i[w] === 1'b1 && bus.waddr_i[w*AW +: AW] == a) begin
        hit = 1'b1;
        d   = bus.wdata_i[w*DW +: DW];
      end
    end
    return hit;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < NWORDS; a++) begin
        m_mem[a]  = '0;
        m_busy[a] = 1'b0;
      end
      m_valid = 1'b1;
    end else if (m_valid) begin
      for (int a = 1; a < NWORDS; a++) begin
        mdl_hit = write_hit(AW'(a), mdl_d);
        if (mdl_hit) m_mem[a] = mdl_d;
        if (bus.sb_set_i && bus.sb_addr_i == AW'(a)) m_busy[a] = 1'b1;
        else if (mdl_hit)                            m_busy[a] = 1'b0;
      end
    end
  end

  function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    logic [DW-1:0] d;
    if (a == '0) return '0;
    r = m_mem[a];
`ifdef CV32E41P_RF_WRITE_BYPASS_EN
    if (write_hit(a, d)) r = d;
`else
    d = '0;
`endif
    return r;
  endfunction

  function automatic logic exp_rbusy(input logic [AW-1:0] a);
    logic          r;
    logic [DW-1:0] d;
    if (a == '0) return 1'b0;
    r = m_busy[a];
`ifdef CV32E41P_RF_WRITE_BYPASS_EN
    if (write_hit(a, d)) r = bus.sb_set_i && (bus.sb_addr_i == a);
`else
    d = '0;
`endif
    return r;
  endfunction

  // Per-cycle comparison of every read port and any_busy against the model
  always @(negedge clk) begin
    if (m_valid) begin
      logic any_exp;
      any_exp = 1'b0;
      for (int a = 0; a < NWORDS; a++) any_exp = any_exp | m_busy[a];
      for (int p = 0; p < NR; p++) begin
        logic [AW-1:0] a;
        a = bus.raddr_i[p*AW +: AW];
        chk($sformatf("model_rdata[%0d]@%0d", p, a), rd(p), exp_rdata(a));
        chk($sformatf("model_rbusy[%0d]@%0d", p, a), DW'(rb(p)), DW'(exp_rbusy(a)));
      end
      chk("model_any_busy", DW'(bus.any_busy_o), DW'(any_exp));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we_i      = '0;
    bus.waddr_i   = '0;
    bus.wdata_i   = '0;
    bus.sb_set_i  = 1'b0;
    bus.sb_addr_i = '0;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we_i[port]               = 1'b1;
    bus.waddr_i[port*AW +: AW]   = a;
    bus.wdata_i[port*DW +: DW]   = d;
  endtask

  task automatic sb(input logic [AW-1:0] a);
    bus.sb_set_i  = 1'b1;
    bus.sb_addr_i = a;
  endtask

  task automatic rdall(input logic [AW-1:0] a2, input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    bus.raddr_i = {a2, a1, a0};
  endtask

  initial begin
    // Reset held two cycles against full write/set traffic on register 7
    rst = 1'b1;
    rdall(5'd0, 5'd0, 5'd0);
    bus.we_i      = '1;
    bus.waddr_i   = {5'd7, 5'd7};
    bus.wdata_i   = {32'h1111_1111, 32'h2222_2222};
    bus.sb_set_i  = 1'b1;
    bus.sb_addr_i = 5'd7;
    cyc(); cyc();
    rst = 1'b0;
    idle();
    rdall(5'd7, 5'd31, 5'd7);
    @(negedge clk);
    chk("rst_rdata7", rd(0), 32'h0);
    chk("rst_rdata31", rd(1), 32'h0);
    chk("rst_rbusy7", DW'(rb(0)), 32'h0);
    chk("rst_any_busy", DW'(bus.any_busy_o), 32'h0);
    #1;

    wr(0, 5'd5, 32'hDEAD_BEEF); cyc(); idle();
    rdall(5'd5, 5'd5, 5'd5);
    @(negedge clk);
    for (int p = 0; p < NR; p++) chk($sformatf("basic_rd_port%0d", p), rd(p), 32'hDEAD_BEEF);
    #1;

    wr(0, 5'd0, 32'h0000_1234); cyc(); idle();
    rdall(5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("zero_reg_read", rd(0), 32'h0);
    #1;

    wr(0, 5'd9, 32'hAAAA_0000); wr(1, 5'd9, 32'h5555_FFFF); cyc(); idle();
    rdall(5'd9, 5'd9, 5'd9);
    @(negedge clk);
    chk("conflict_same_addr", rd(0), 32'h5555_FFFF);
    #1;

    wr(0, 5'd9, 32'h0101_0101); wr(1, 5'd10, 32'h0202_0202); cyc(); idle();
    rdall(5'd9, 5'd9, 5'd10);
    @(negedge clk);
    chk("distinct_addr10", rd(0), 32'h0202_0202);
    chk("distinct_addr9", rd(1), 32'h0101_0101);
    #1;

    sb(5'd12); cyc(); idle();
    rdall(5'd12, 5'd12, 5'd12);
    @(negedge clk);
    chk("sb_set_busy", DW'(rb(0)), 32'h1);
    chk("sb_set_any", DW'(bus.any_busy_o), 32'h1);
    #1;

    wr(1, 5'd12, 32'h0C0C_0C0C); cyc(); idle();
    @(negedge clk);
    chk("sb_clear_busy", DW'(rb(0)), 32'h0);
    chk("sb_clear_data", rd(0), 32'h0C0C_0C0C);
    chk("sb_clear_any", DW'(bus.any_busy_o), 32'h0);
    #1;

    sb(5'd12); wr(1, 5'd12, 32'h0000_0077); cyc(); idle();
    @(negedge clk);
    chk("sb_set_wins_busy", DW'(rb(0)), 32'h1);
    chk("sb_set_wins_data", rd(0), 32'h0000_0077);
    #1;
    wr(0, 5'd12, 32'h0); cyc(); idle();

    // Same-cycle read of a register being written
    wr(0, 5'd3, 32'hCAFE_F00D);
    rdall(5'd3, 5'd3, 5'd3);
    @(negedge clk);
`ifdef CV32E41P_RF_WRITE_BYPASS_EN
    chk("bypass_same_cycle", rd(0), 32'hCAFE_F00D);
`else
    chk("bypass_same_cycle", rd(0), 32'h0);
`endif
    #1;
    cyc(); idle();
    @(negedge clk);
    chk("bypass_committed", rd(0), 32'hCAFE_F00D);
    #1;

    for (int a = 1; a <= 3; a++) begin
      wr(0, AW'(a), 32'h1000_0000 + DW'(a)); sb(AW'(a)); cyc(); idle();
    end
    rdall(5'd3, 5'd2, 5'd1);
    @(negedge clk);
    chk("mid_busy1", DW'(rb(0)), 32'h1);
    chk("mid_data1", rd(0), 32'h1000_0001);
    chk("mid_any", DW'(bus.any_busy_o), 32'h1);
    #1;
    rst = 1'b1;
    wr(0, 5'd4, 32'hFFFF_FFFF);
    cyc();
    rst = 1'b0;
    idle();
    rdall(5'd4, 5'd2, 5'd1);
    @(negedge clk);
    chk("mid_rst_addr4", rd(2), 32'h0);
    chk("mid_rst_data1", rd(0), 32'h0);
    chk("mid_rst_data2", rd(1), 32'h0);
    chk("mid_rst_busy1", DW'(rb(0)), 32'h0);
    chk("mid_rst_any", DW'(bus.any_busy_o), 32'h0);
    #1;

    // Randomized traffic, addresses biased to a small pool to provoke conflicts
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] pool_a;
      pool_a = AW'($urandom_range(0, 7));
      rst = ($urandom_range(0, 79) == 0);
      bus.we_i = NW'($urandom);
      for (int w = 0; w < NW; w++) begin
        bus.waddr_i[w*AW +: AW] = ($urandom_range(0, 2) == 0) ? pool_a :
                                  (($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom));
        bus.wdata_i[w*DW +: DW] = $urandom;
      end
      bus.sb_set_i  = ($urandom_range(0, 2) == 0);
      bus.sb_addr_i = ($urandom_range(0, 1) == 0) ? pool_a : AW'($urandom_range(0, 7));
      for (int p = 0; p < NR; p++) begin
        bus.raddr_i[p*AW +: AW] = ($urandom_range(0, 1) == 0) ? pool_a : AW'($urandom_range(0, 7));
      end
      cyc();
    end

    rst = 1'b0;
    idle();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cv32e41p_register_file_mp.md
Name: cv32e41p_register_file_mp

Overview:
- Flip-flop based, fully parametrised multi-port integer register file for the cv32e41p core.
- Configurable word count, data width, read-port count and write-port count.
- Deterministic priority between write ports.
- Per-register pending-write scoreboard, so the ID stage can stall on outstanding long-latency writebacks (LSU, multi-cycle MUL/DIV) without a separate hazard unit.

Parameters:
- ADDR_WIDTH, 5: address bits; NUM_WORDS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32: register width in bits.
- NUM_RPORTS, 3: number of read ports (1..4).
- NUM_WPORTS, 2: number of write ports (1..3); a higher port index has higher priority.
- ZERO_REG, 1: 1 = word 0 reads 0 and ignores writes/scoreboard; 0 = word 0 is an ordinary register.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- raddr_i  in  NUM_RPORTS*ADDR_WIDTH  read addresses; port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- rdata_o  out  NUM_RPORTS*DATA_WIDTH  read data, packed the same way.
- rbusy_o  out  NUM_RPORTS  scoreboard busy bit of the register addressed on each read port.
- waddr_i  in  NUM_WPORTS*ADDR_WIDTH  write addresses.
- wdata_i  in  NUM_WPORTS*DATA_WIDTH  write data.
- we_i  in  NUM_WPORTS  write enables.
- sb_set_i  in  1  mark register sb_addr_i as pending (long-latency instruction issued).
- sb_addr_i  in  ADDR_WIDTH  scoreboard set address.
- any_busy_o  out  1  OR of all busy bits (used for fence/debug entry).

Behaviour:
- Storage: NUM_WORDS x DATA_WIDTH flops mem[], plus NUM_WORDS busy bits busy[].
- Reset: when rst=1 at a rising edge, every mem word becomes 0 and every busy bit becomes 0. Rst has priority over all writes and scoreboard sets in the same cycle.
- After reset: rdata_o=0, rbusy_o=0, any_busy_o=0.
- Read path is combinational:
  - rdata_o[p] = mem[raddr[p]].
  - rbusy_o[p] = busy[raddr[p]].
  - With ZERO_REG=1, address 0 always returns data 0 and busy 0.
- Write latency: a write with we_i[w]=1 at edge N is visible on the read ports after edge N.
  - Same-cycle read of the address being written returns the old value (see Optional Feature).
- Write conflict: when several enabled ports target the same address, the highest-index port's data is stored. Writes to different addresses all commit in the same cycle.
- Writes to address 0 are discarded when ZERO_REG=1.
- Scoreboard, per address a, next-state priority:
  - rst → busy[a]=0.
  - else sb_set_i && sb_addr_i==a → busy[a]=1. A set wins over a same-cycle clear, because a new pending writer supersedes the retiring one.
  - else any we_i[w] with waddr[w]==a → busy[a]=0.
  - else busy[a] holds.
- Scoreboard set for address 0 is ignored when ZERO_REG=1.
- Scoreboard set and a write to different addresses in the same cycle: both take effect independently.
- A write to a non-busy register is legal and leaves busy at 0.
- any_busy_o is the combinational OR of busy[].
- No clock gating and no latches; flops only, DFT-clean.

Optional Feature:
- Macro: CV32E41P_RF_WRITE_BYPASS_EN.
- Defined: the read paths forward same-cycle write data.
  - If any we_i[w]=1 with waddr[w]==raddr[p] (and address ≠0 when ZERO_REG=1), rdata_o[p] returns the highest-priority matching wdata_i in the same cycle.
  - rbusy_o[p] returns 0 for that port in that cycle unless sb_set_i targets the same address, in which case it returns 1.
- Undefined: no forwarding; reads always reflect the registered state only. Forwarding logic is absent from the netlist.

Test Plan:
- Reset then read: assert rst for 2 cycles with we_i=all 1s and sb_set_i=1 on addr 7 → after release, reading addr 7 and addr 31 gives rdata 0, rbusy 0, any_busy_o 0.
- Basic write/read: write 0xDEADBEEF to addr 5 via port 0 → next cycle, all read ports at addr 5 return 0xDEADBEEF. A write of 0x1234 to addr 0 → addr 0 still reads 0 (ZERO_REG=1).
- Write conflict: same cycle, port0 writes 0xAAAA0000 and port1 writes 0x5555FFFF to addr 9 → addr 9 reads 0x5555FFFF. Same test with distinct addresses 9 and 10 → both values stored.
- Scoreboard:
  - sb_set_i on addr 12 → rbusy=1 and any_busy_o=1 from the next cycle.
  - Port1 write to addr 12 → busy clears the following cycle.
  - sb_set_i plus a write to addr 12 in the same cycle → busy stays 1 and data is updated.
- Bypass: write 0xCAFEF00D to addr 3 while reading addr 3 in the same cycle → 0xCAFEF00D in that cycle when CV32E41P_RF_WRITE_BYPASS_EN is defined, old value when it is not.
- Reset mid-operation: busy set on addrs 1, 2, 3 with data written, then rst for 1 cycle with a concurrent write of 0xFFFFFFFF to addr 4 → all data 0, all busy 0, addr 4 reads 0.
